// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: bus commands,
// tag-table entry layout, grant encoding and a small popcount helper.
package dmem_arbiter_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int TAG_W         = 4;
  localparam int NUM_TAGS      = 15;
  localparam int DEF_LQ_IDX_W  = 3;

  typedef struct packed {
    logic                    valid;
    logic [DEF_LQ_IDX_W-1:0] idx;
  } DMEM_TAG_ENTRY;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_ST   = 2'd2
  } DMEM_GRANT;

  // Tag 0 means "no tag" on the bus, so only entries 1..15 are ever counted.
  function automatic logic [TAG_W-1:0] popcount_tags(input logic [NUM_TAGS:1] v);
    logic [TAG_W-1:0] n;
    n = '0;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      n = n + TAG_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request, memory-bus and load-response signals of the data-memory arbiter.
// master = the arbiter itself, slave = the pipeline/memory environment.
interface dmem_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int LQ_IDX_W = 3
);
  logic                ld_req_valid;
  logic [XLEN-1:0]     ld_req_addr;
  logic [LQ_IDX_W-1:0] ld_req_idx;
  logic                ld_req_ready;

  logic                st_req_valid;
  logic [XLEN-1:0]     st_req_addr;
  logic [XLEN-1:0]     st_req_data;
  logic                st_req_ready;

  logic                squash;

  logic [1:0]          proc2Dmem_command;
  logic [XLEN-1:0]     proc2Dmem_addr;
  logic [XLEN-1:0]     proc2Dmem_data;
  logic [3:0]          Dmem2proc_response;
  logic [3:0]          Dmem2proc_tag;
  logic [XLEN-1:0]     Dmem2proc_data;

  logic                ld_resp_valid;
  logic [LQ_IDX_W-1:0] ld_resp_idx;
  logic [XLEN-1:0]     ld_resp_data;
  logic [3:0]          ld_outstanding;

  modport master (
    input  ld_req_valid, ld_req_addr, ld_req_idx,
    output ld_req_ready,
    input  st_req_valid, st_req_addr, st_req_data,
    output st_req_ready,
    input  squash,
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
    output ld_resp_valid, ld_resp_idx, ld_resp_data, ld_outstanding
  );

  modport slave (
    output ld_req_valid, ld_req_addr, ld_req_idx,
    input  ld_req_ready,
    output st_req_valid, st_req_addr, st_req_data,
    input  st_req_ready,
    output squash,
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
    input  ld_resp_valid, ld_resp_idx, ld_resp_data, ld_outstanding
  );
endinterface

// File: rtl/dmem_tag_table.sv
// Tag-indexed table of outstanding loads: memory tag -> load-queue slot.
// Free is applied before alloc so a recycled tag keeps its new owner.
module dmem_tag_table
  import dmem_arbiter_pkg::*;
#(
  parameter int LQ_IDX_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_en,
  input  logic [TAG_W-1:0]    alloc_tag,
  input  logic [LQ_IDX_W-1:0] alloc_idx,
  input  logic                free_en,
  input  logic [TAG_W-1:0]    free_tag,
  input  logic                flush,
  input  logic [TAG_W-1:0]    lookup_tag,
  output logic                lookup_valid,
  output logic [LQ_IDX_W-1:0] lookup_idx,
  output logic [TAG_W-1:0]    count
);

  // Slot 0 exists only so tag 0 indexes safely; it is never set.
  logic [15:0]         valid_q;
  logic [LQ_IDX_W-1:0] idx_q [16];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < 16; i++) begin
        idx_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (free_en && free_tag != '0) begin
        valid_q[free_tag] <= 1'b0;
      end
      if (alloc_en && alloc_tag != '0) begin
        assert (!valid_q[alloc_tag] || (free_en && free_tag == alloc_tag))
          else $error("dmem_tag_table: load accepted with tag %0d already in use", alloc_tag);
        valid_q[alloc_tag] <= 1'b1;
        idx_q[alloc_tag]   <= alloc_idx;
      end
    end
  end

  assign lookup_valid = valid_q[lookup_tag];
  assign lookup_idx   = idx_q[lookup_tag];
  assign count        = popcount_tags(valid_q[NUM_TAGS:1]);

endmodule

// File: rtl/dmem_arbiter.sv
// Grants the shared data-memory port to the load unit or the store drain,
// tracks accepted load tags and returns load data to its load-queue slot.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int LQ_IDX_W      = 3,
  parameter int MAX_LD_OUT    = 8,
  parameter int MAX_ST_STREAK = 4
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.master bus
);

  localparam int STREAK_W = $clog2(MAX_ST_STREAK + 1);

  DMEM_GRANT           grant;
  logic                ld_elig;
  logic                prio_ld;
  logic                mem_accept;
  logic                ld_acc;
  logic                st_acc;
  logic [1:0]          cmd;
  logic [XLEN-1:0]     addr;
  logic [XLEN-1:0]     wdata;

  logic [STREAK_W-1:0] st_streak;
  logic [TAG_W-1:0]    outstanding;
  logic                tag_hit;
  logic [LQ_IDX_W-1:0] tag_idx;

  logic                resp_valid_q;
  logic [LQ_IDX_W-1:0] resp_idx_q;
  logic [XLEN-1:0]     resp_data_q;

  always_comb begin
    ld_elig = bus.ld_req_valid && (outstanding < TAG_W'(MAX_LD_OUT)) && !bus.squash;
    prio_ld = (st_streak == STREAK_W'(MAX_ST_STREAK));
    grant   = GNT_NONE;
    if (!reset) begin
      grant = GNT_NONE;
    end else if (bus.st_req_valid && !(prio_ld && ld_elig)) begin
      grant = GNT_ST;
    end else if (ld_elig) begin
      grant = GNT_LD;
    end
  end

  always_comb begin
    cmd   = BUS_NONE;
    addr  = '0;
    wdata = '0;
    case (grant)
      GNT_LD: begin
        cmd  = BUS_LOAD;
        addr = bus.ld_req_addr;
      end
      GNT_ST: begin
        cmd   = BUS_STORE;
        addr  = bus.st_req_addr;
        wdata = bus.st_req_data;
      end
      default: ;
    endcase
  end

  assign mem_accept = (grant != GNT_NONE) && (bus.Dmem2proc_response != 4'd0);
  assign ld_acc     = mem_accept && (grant == GNT_LD);
  assign st_acc     = mem_accept && (grant == GNT_ST);

  dmem_tag_table #(.LQ_IDX_W(LQ_IDX_W)) u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (ld_acc),
    .alloc_tag    (bus.Dmem2proc_response),
    .alloc_idx    (bus.ld_req_idx),
    .free_en      (tag_hit),
    .free_tag     (bus.Dmem2proc_tag),
    .flush        (bus.squash),
    .lookup_tag   (bus.Dmem2proc_tag),
    .lookup_valid (tag_hit),
    .lookup_idx   (tag_idx),
    .count        (outstanding)
  );

  // Stores only count against fairness while a load is actually waiting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_streak <= '0;
    end else if (ld_acc || !bus.ld_req_valid) begin
      st_streak <= '0;
    end else if (st_acc && !prio_ld) begin
      st_streak <= st_streak + STREAK_W'(1);
    end
  end

  // A squash kills the delivery of a tag returning in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= tag_hit && !bus.squash;
      if (tag_hit) begin
        resp_idx_q  <= tag_idx;
        resp_data_q <= bus.Dmem2proc_data;
      end
    end
  end

  assign bus.proc2Dmem_command = cmd;
  assign bus.proc2Dmem_addr    = addr;
  assign bus.proc2Dmem_data    = wdata;
  assign bus.ld_req_ready      = ld_acc;
  assign bus.st_req_ready      = st_acc;
  assign bus.ld_resp_valid     = resp_valid_q;
  assign bus.ld_resp_idx       = resp_idx_q;
  assign bus.ld_resp_data      = resp_data_q;
  assign bus.ld_outstanding    = outstanding;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random stimulus for dmem_arbiter, checked against a
// tag-table reference model kept in the bench.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;

  dmem_arbiter_if #(.XLEN(32), .LQ_IDX_W(3)) bus ();

  dmem_arbiter #(.XLEN(32), .LQ_IDX_W(3), .MAX_LD_OUT(8), .MAX_ST_STREAK(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  DMEM_TAG_ENTRY m_tbl [16];
  int            m_streak;
  logic          m_rv;
  logic [2:0]    m_ridx;
  logic [31:0]   m_rdata;

  logic [1:0]    obs_cmd;
  logic          obs_ld_ready;
  logic          obs_st_ready;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int t = 1; t <= 15; t++) if (m_tbl[t].valid) n++;
    return n;
  endfunction

  task automatic m_clear();
    for (int t = 0; t < 16; t++) m_tbl[t] = '0;
    m_streak = 0;
    m_rv     = 1'b0;
    m_ridx   = '0;
    m_rdata  = '0;
  endtask

  task automatic drive(input logic ldv, input logic [31:0] lda, input logic [2:0] ldi,
                       input logic stv, input logic [31:0] sta, input logic [31:0] std,
                       input logic sq, input logic [3:0] resp, input logic [3:0] tag,
                       input logic [31:0] rdata);
    bus.ld_req_valid       = ldv;
    bus.ld_req_addr        = lda;
    bus.ld_req_idx         = ldi;
    bus.st_req_valid       = stv;
    bus.st_req_addr        = sta;
    bus.st_req_data        = std;
    bus.squash             = sq;
    bus.Dmem2proc_response = resp;
    bus.Dmem2proc_tag      = tag;
    bus.Dmem2proc_data     = rdata;
  endtask

  task automatic idle(input logic [3:0] tag, input logic [31:0] rdata);
    drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, tag, rdata);
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    int         cnt;
    bit         ld_ok, ld_gnt, st_gnt, acc, hit;
    logic [1:0] e_cmd;
    logic [31:0] e_addr, e_data;
    int         tg, rs;
    @(negedge clock);
    cnt    = m_count();
    ld_ok  = bus.ld_req_valid && (cnt < 8) && !bus.squash;
    ld_gnt = 0;
    st_gnt = 0;
    if (reset) begin
      if (bus.st_req_valid && !(m_streak == 4 && ld_ok)) st_gnt = 1;
      else if (ld_ok) ld_gnt = 1;
    end
    e_cmd  = st_gnt ? BUS_STORE : (ld_gnt ? BUS_LOAD : BUS_NONE);
    e_addr = st_gnt ? bus.st_req_addr : (ld_gnt ? bus.ld_req_addr : 32'h0);
    e_data = st_gnt ? bus.st_req_data : 32'h0;
    acc    = (ld_gnt || st_gnt) && (bus.Dmem2proc_response != 0);
    obs_cmd      = bus.proc2Dmem_command;
    obs_ld_ready = bus.ld_req_ready;
    obs_st_ready = bus.st_req_ready;
    chk("command", 32'(obs_cmd), 32'(e_cmd));
    chk("addr", bus.proc2Dmem_addr, e_addr);
    chk("wdata", bus.proc2Dmem_data, e_data);
    chk("ld_req_ready", 32'(obs_ld_ready), 32'(acc && ld_gnt));
    chk("st_req_ready", 32'(obs_st_ready), 32'(acc && st_gnt));
    chk("ld_outstanding", 32'(bus.ld_outstanding), 32'(cnt));
    chk("ld_resp_valid", 32'(bus.ld_resp_valid), 32'(m_rv));
    if (m_rv) begin
      chk("ld_resp_idx", 32'(bus.ld_resp_idx), 32'(m_ridx));
      chk("ld_resp_data", bus.ld_resp_data, m_rdata);
    end
    @(posedge clock);
    if (!reset) begin
      m_clear();
    end else begin
      tg  = int'(bus.Dmem2proc_tag);
      rs  = int'(bus.Dmem2proc_response);
      hit = (tg != 0) && m_tbl[tg].valid;
      m_rv = hit && !bus.squash;
      if (hit) begin
        m_ridx  = m_tbl[tg].idx;
        m_rdata = bus.Dmem2proc_data;
      end
      if (bus.squash) begin
        for (int t = 0; t < 16; t++) m_tbl[t].valid = 1'b0;
      end else begin
        if (hit) m_tbl[tg].valid = 1'b0;
        if (acc && ld_gnt) begin
          m_tbl[rs].valid = 1'b1;
          m_tbl[rs].idx   = bus.ld_req_idx;
        end
      end
      if ((acc && ld_gnt) || !bus.ld_req_valid) m_streak = 0;
      else if (acc && st_gnt && m_streak < 4) m_streak++;
    end
    #1;
  endtask

  task automatic rand_step();
    logic [3:0] tag, resp;
    int r, t;
    tag = 4'd0;
    r = $urandom_range(0, 9);
    if (r >= 4 && r < 8) begin
      for (int k = 0; k < 8; k++) begin
        t = $urandom_range(1, 15);
        if (m_tbl[t].valid) begin
          tag = 4'(t);
          break;
        end
      end
    end else if (r >= 8) begin
      tag = 4'($urandom_range(1, 15));
    end
    resp = 4'd0;
    if ($urandom_range(0, 4) != 0) begin
      do t = $urandom_range(1, 15); while (m_tbl[t].valid && t != int'(tag));
      resp = 4'(t);
    end
    drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), $urandom, $urandom,
          $urandom_range(0, 39) == 0, resp, tag, $urandom);
    cycle();
  endtask

  initial begin
    m_clear();
    reset = 1'b0;
    drive(1'b1, 32'h40, 3'd1, 1'b1, 32'h80, 32'h55, 1'b0, 4'd3, 4'd0, 32'h0);
    cycle();
    chk("rst_cmd", 32'(obs_cmd), 32'(BUS_NONE));
    cycle();
    chk("rst_resp_idx", 32'(bus.ld_resp_idx), 32'd0);
    chk("rst_resp_data", bus.ld_resp_data, 32'd0);
    idle(4'd0, 32'h0);
    #1 reset = 1'b1;

    // single load, tag returns three cycles later
    drive(1'b1, 32'h100, 3'd3, 1'b0, 32'h0, 32'h0, 1'b0, 4'd5, 4'd0, 32'h0);
    cycle();
    chk("t1_ld_ready", 32'(obs_ld_ready), 32'd1);
    idle(4'd0, 32'h0);
    cycle();
    cycle();
    idle(4'd5, 32'hDEADBEEF);
    cycle();
    chk("t1_resp_valid", 32'(bus.ld_resp_valid), 32'd1);
    chk("t1_resp_idx", 32'(bus.ld_resp_idx), 32'd3);
    chk("t1_resp_data", bus.ld_resp_data, 32'hDEADBEEF);
    idle(4'd0, 32'h0);
    cycle();

    // store streak then forced load
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 3'(i), 1'b1, 32'h300 + 32'(i), 32'hA000 + 32'(i),
            1'b0, 4'(i + 1), 4'd0, 32'h0);
      cycle();
      chk("t2_grant", 32'(obs_cmd), (i % 5 == 4) ? 32'(BUS_LOAD) : 32'(BUS_STORE));
    end
    idle(4'd5, 32'h11);
    cycle();
    idle(4'd10, 32'h22);
    cycle();

    // fill to MAX_LD_OUT
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h400 + 32'(i), 3'(i), 1'b0, 32'h0, 32'h0, 1'b0, 4'(i + 1), 4'd0, 32'h0);
      cycle();
    end
    chk("t3_outstanding", 32'(bus.ld_outstanding), 32'd8);
    drive(1'b1, 32'h500, 3'd7, 1'b1, 32'h600, 32'h77, 1'b0, 4'd9, 4'd0, 32'h0);
    cycle();
    chk("t3_full_store", 32'(obs_cmd), 32'(BUS_STORE));
    chk("t3_full_ld_ready", 32'(obs_ld_ready), 32'd0);
    drive(1'b1, 32'h500, 3'd7, 1'b0, 32'h0, 32'h0, 1'b0, 4'd9, 4'd1, 32'h33);
    cycle();
    chk("t3_still_full", 32'(obs_cmd), 32'(BUS_NONE));
    drive(1'b1, 32'h500, 3'd7, 1'b0, 32'h0, 32'h0, 1'b0, 4'd9, 4'd0, 32'h0);
    cycle();
    chk("t3_regrant", 32'(obs_ld_ready), 32'd1);
    for (int t = 2; t <= 9; t++) begin
      idle(4'(t), 32'h1000 + 32'(t));
      cycle();
    end
    idle(4'd0, 32'h0);
    cycle();

    // squash drops outstanding loads
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'h700, 3'(i), 1'b0, 32'h0, 32'h0, 1'b0, 4'(i), 4'd0, 32'h0);
      cycle();
    end
    drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd0, 4'd1, 32'h44);
    cycle();
    chk("t4_outstanding", 32'(bus.ld_outstanding), 32'd0);
    chk("t4_squash_resp", 32'(bus.ld_resp_valid), 32'd0);
    for (int t = 2; t <= 3; t++) begin
      idle(4'(t), 32'h55);
      cycle();
      chk("t4_dropped", 32'(bus.ld_resp_valid), 32'd0);
    end

    // rejected four times, accepted on the fifth
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h800, 3'd5, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0, 32'h0);
      cycle();
      chk("t5_reject", 32'(obs_ld_ready), 32'd0);
    end
    drive(1'b1, 32'h800, 3'd5, 1'b0, 32'h0, 32'h0, 1'b0, 4'd2, 4'd0, 32'h0);
    cycle();
    chk("t5_accept", 32'(obs_ld_ready), 32'd1);
    chk("t5_outstanding", 32'(bus.ld_outstanding), 32'd1);

    // same-cycle free and reuse of tag 2
    drive(1'b1, 32'h900, 3'd6, 1'b0, 32'h0, 32'h0, 1'b0, 4'd2, 4'd2, 32'h1234);
    cycle();
    chk("t6_old_idx", 32'(bus.ld_resp_idx), 32'd5);
    chk("t6_old_data", bus.ld_resp_data, 32'h1234);
    chk("t6_outstanding", 32'(bus.ld_outstanding), 32'd1);
    idle(4'd2, 32'hABCD);
    cycle();
    chk("t6_new_idx", 32'(bus.ld_resp_idx), 32'd6);
    idle(4'd0, 32'h0);
    cycle();

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset = 1'b0;
        m_clear();
        cycle();
        chk("mid_rst_outstanding", 32'(bus.ld_outstanding), 32'd0);
        reset = 1'b1;
      end
      rand_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
